// File: rtl/fft_pkg.sv
// Shared definitions for the in-place radix-2 FFT address generator:
// controller state encoding plus the bit-reverse, zero-insert and
// twiddle-index helpers. Helpers work on MAX_LOG2-bit vectors and take
// the active width as an argument, so callers truncate the result.
package fft_pkg;

    localparam int MAX_LOG2 = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STAGE_WAIT,
        FIN
    } fft_state_t;

    // Reverse the lowest n bits of v; the bits above n come back as zero.
    function automatic logic [MAX_LOG2-1:0] bit_reverse(input logic [MAX_LOG2-1:0] v,
                                                        input int n);
        logic [MAX_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2; i++) begin
            if (i < n) begin
                r[n-1-i] = v[i];
            end
        end
        return r;
    endfunction

    // Open a zero at bit position pos: bits below pos stay, bits at or
    // above pos move up by one. This turns a butterfly index into the
    // address of the top element of the pair.
    function automatic logic [MAX_LOG2-1:0] insert_zero(input logic [MAX_LOG2-1:0] j,
                                                        input int pos);
        logic [MAX_LOG2-1:0] r;
        r = '0;
        r[0] = (pos == 0) ? 1'b0 : j[0];
        for (int i = 1; i < MAX_LOG2; i++) begin
            if (i < pos) begin
                r[i] = j[i];
            end else if (i > pos) begin
                r[i] = j[i-1];
            end
        end
        return r;
    endfunction

    // Twiddle exponent for butterfly j in stage s of an n-bit FFT:
    // (j mod 2^s) shifted up by n-1-s.
    function automatic logic [MAX_LOG2-1:0] twiddle_index(input logic [MAX_LOG2-1:0] j,
                                                          input int s,
                                                          input int n);
        logic [MAX_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2; i++) begin
            if (i < s) begin
                r[i + n - 1 - s] = j[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous clear. Carries the
// read-side strobe and addresses forward to the write-back side.
module fft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Shift one tap per clock; clear empties the whole line at once.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/fft_addr_gen.sv
// Address generator for an in-place radix-2 FFT over N = 2^N_LOG2 points.
// Walks N_LOG2 stages of N/2 butterflies, pausing PIPE_LAT cycles between
// stages so the last write of a stage lands before the next stage reads.
// Optional macro FFT_AG_BITREV_EN adds a bit-reversed load phase with
// outputs LOAD_ADDR / LOAD_VALID ahead of stage 0.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N_LOG2   = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START,
    input  logic                        STALL,
    output logic                        BUSY,
    output logic                        DONE,
    output logic [N_LOG2-1:0]           ADDRA,
    output logic [N_LOG2-1:0]           ADDRB,
    output logic [N_LOG2-2:0]           TW_IDX,
    output logic [$clog2(N_LOG2)-1:0]   STAGE,
    output logic                        BFLY_VALID,
    output logic                        WR_EN,
    output logic [N_LOG2-1:0]           WR_ADDRA,
    output logic [N_LOG2-1:0]           WR_ADDRB
`ifdef FFT_AG_BITREV_EN
    ,
    output logic [N_LOG2-1:0]           LOAD_ADDR,
    output logic                        LOAD_VALID
`endif
);

    localparam int N    = 1 << N_LOG2;
    localparam int HALF = N / 2;
    localparam int JW   = N_LOG2 - 1;
    localparam int SW   = $clog2(N_LOG2);
    localparam int WCW  = $clog2(PIPE_LAT + 1);
    localparam int DW   = 1 + 2 * N_LOG2;

    fft_state_t      state, state_n;
    logic [JW-1:0]   j, j_n;
    logic [WCW-1:0]  wait_cnt, wait_n;
    logic [SW-1:0]   stage_n;
    logic            busy_n, done_n, valid_n;
    logic [N_LOG2-1:0] addra_n, addrb_n;
    logic [JW-1:0]   tw_n;

    logic [N_LOG2-1:0] ins_addr;
    logic [N_LOG2-1:0] span;
    logic [JW-1:0]     tw_calc;
    logic [DW-1:0]     dly_out;

`ifdef FFT_AG_BITREV_EN
    logic [N_LOG2-1:0] load_cnt, load_cnt_n;
    logic [N_LOG2-1:0] load_addr_n;
    logic              load_valid_n;
    logic [N_LOG2-1:0] rev_addr;

    assign rev_addr = N_LOG2'(bit_reverse(MAX_LOG2'(load_cnt), N_LOG2));
`endif

    assign ins_addr = N_LOG2'(insert_zero(MAX_LOG2'(j), int'(STAGE)));
    assign span     = N_LOG2'(1) << STAGE;
    assign tw_calc  = JW'(twiddle_index(MAX_LOG2'(j), int'(STAGE), N_LOG2));

    // Next-state and next-output decode for the sequencing FSM.
    always_comb begin
        state_n = state;
        j_n     = j;
        wait_n  = wait_cnt;
        stage_n = STAGE;
        busy_n  = BUSY;
        done_n  = 1'b0;
        valid_n = 1'b0;
        addra_n = ADDRA;
        addrb_n = ADDRB;
        tw_n    = TW_IDX;
`ifdef FFT_AG_BITREV_EN
        load_cnt_n   = load_cnt;
        load_addr_n  = LOAD_ADDR;
        load_valid_n = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (START) begin
                    busy_n  = 1'b1;
                    j_n     = '0;
                    wait_n  = '0;
                    stage_n = '0;
`ifdef FFT_AG_BITREV_EN
                    load_cnt_n = '0;
                    state_n    = LOAD;
`else
                    state_n    = RUN;
`endif
                end
            end
`ifdef FFT_AG_BITREV_EN
            LOAD: begin
                if (!STALL) begin
                    load_valid_n = 1'b1;
                    load_addr_n  = rev_addr;
                    load_cnt_n   = load_cnt + N_LOG2'(1);
                    if (load_cnt == N_LOG2'(N - 1)) begin
                        load_cnt_n = '0;
                        state_n    = RUN;
                    end
                end
            end
`endif
            RUN: begin
                if (!STALL) begin
                    valid_n = 1'b1;
                    addra_n = ins_addr;
                    addrb_n = ins_addr + span;
                    tw_n    = tw_calc;
                    if (j == JW'(HALF - 1)) begin
                        j_n     = '0;
                        wait_n  = '0;
                        state_n = STAGE_WAIT;
                    end else begin
                        j_n = j + JW'(1);
                    end
                end
            end
            STAGE_WAIT: begin
                if (wait_cnt == WCW'(PIPE_LAT - 1)) begin
                    wait_n = '0;
                    if (STAGE == SW'(N_LOG2 - 1)) begin
                        state_n = FIN;
                    end else begin
                        stage_n = STAGE + SW'(1);
                        state_n = RUN;
                    end
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end
            FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                stage_n = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters and every output are registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            j          <= '0;
            wait_cnt   <= '0;
            STAGE      <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            BFLY_VALID <= 1'b0;
            ADDRA      <= '0;
            ADDRB      <= '0;
            TW_IDX     <= '0;
`ifdef FFT_AG_BITREV_EN
            load_cnt   <= '0;
            LOAD_ADDR  <= '0;
            LOAD_VALID <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            j          <= j_n;
            wait_cnt   <= wait_n;
            STAGE      <= stage_n;
            BUSY       <= busy_n;
            DONE       <= done_n;
            BFLY_VALID <= valid_n;
            ADDRA      <= addra_n;
            ADDRB      <= addrb_n;
            TW_IDX     <= tw_n;
`ifdef FFT_AG_BITREV_EN
            load_cnt   <= load_cnt_n;
            LOAD_ADDR  <= load_addr_n;
            LOAD_VALID <= load_valid_n;
`endif
        end
    end

    fft_delay_line #(
        .WIDTH(DW),
        .DEPTH(PIPE_LAT)
    ) u_wb_delay (
        .clk (CLK),
        .clr (RST),
        .din ({BFLY_VALID, ADDRA, ADDRB}),
        .dout(dly_out)
    );

    assign {WR_EN, WR_ADDRA, WR_ADDRB} = dly_out;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Self-checking bench for fft_addr_gen (N_LOG2=4, PIPE_LAT=2). Expected
// activity per run is a cycle schedule built from the butterfly formulas
// and the chosen stall pattern. Honours FFT_AG_BITREV_EN when defined.
module tb_fft_addr_gen;

    localparam int N_LOG2   = 4;
    localparam int PIPE_LAT = 2;
    localparam int N        = 1 << N_LOG2;
    localparam int HALF     = N / 2;
    localparam int MAXOFF   = 400;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       STALL;
    logic       BUSY, DONE, BFLY_VALID, WR_EN;
    logic [3:0] ADDRA, ADDRB, WR_ADDRA, WR_ADDRB;
    logic [2:0] TW_IDX;
    logic [1:0] STAGE;
`ifdef FFT_AG_BITREV_EN
    logic [3:0] LOAD_ADDR;
    logic       LOAD_VALID;
`endif

    int total = 0;
    int bad   = 0;

    bit stall_at [MAXOFF];
    bit ev       [MAXOFF];
    int ea       [MAXOFF];
    int eb       [MAXOFF];
    int etw      [MAXOFF];
    int est      [MAXOFF];
    bit ew       [MAXOFF];
    int ewa      [MAXOFF];
    int ewb      [MAXOFF];
    bit el       [MAXOFF];
    int eladdr   [MAXOFF];
    int done_off;
    int stage1_off;

    fft_addr_gen #(
        .N_LOG2  (N_LOG2),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .STALL     (STALL),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ADDRA     (ADDRA),
        .ADDRB     (ADDRB),
        .TW_IDX    (TW_IDX),
        .STAGE     (STAGE),
        .BFLY_VALID(BFLY_VALID),
        .WR_EN     (WR_EN),
        .WR_ADDRA  (WR_ADDRA),
        .WR_ADDRB  (WR_ADDRB)
`ifdef FFT_AG_BITREV_EN
        ,
        .LOAD_ADDR (LOAD_ADDR),
        .LOAD_VALID(LOAD_VALID)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < N_LOG2; i++) begin
            if (((v >> i) & 1) != 0) r = r | (1 << (N_LOG2 - 1 - i));
        end
        return r;
    endfunction

    // Lay out the expected schedule for one run, offsets counted from the START edge.
    task automatic build_schedule(input int pct, input int stall_from, input int stall_len);
        int t;
        int a;
        for (int k = 0; k < MAXOFF; k++) begin
            stall_at[k] = ((k >= stall_from) && (k < stall_from + stall_len)) ||
                          ($urandom_range(99) < pct);
            if (k == 0 || k > MAXOFF - 120) stall_at[k] = 1'b0;
            ev[k] = 1'b0; ew[k] = 1'b0; el[k] = 1'b0;
            ea[k] = 0; eb[k] = 0; etw[k] = 0; est[k] = 0;
            ewa[k] = 0; ewb[k] = 0; eladdr[k] = 0;
        end
        t = 1;
`ifdef FFT_AG_BITREV_EN
        for (int n = 0; n < N; n++) begin
            while (stall_at[t]) t++;
            el[t] = 1'b1;
            eladdr[t] = bitrev(n);
            t++;
        end
`endif
        stage1_off = 0;
        for (int s = 0; s < N_LOG2; s++) begin
            if (s > 0) t = t + PIPE_LAT;
            for (int j = 0; j < HALF; j++) begin
                while (stall_at[t]) t++;
                if (s == 1 && j == 0) stage1_off = t;
                a = (j / (1 << s)) * (1 << (s + 1)) + (j % (1 << s));
                ev[t]  = 1'b1;
                ea[t]  = a;
                eb[t]  = a + (1 << s);
                etw[t] = (j % (1 << s)) << (N_LOG2 - 1 - s);
                est[t] = s;
                ew[t + PIPE_LAT]  = 1'b1;
                ewa[t + PIPE_LAT] = a;
                ewb[t + PIPE_LAT] = a + (1 << s);
                t++;
            end
        end
        done_off = t + PIPE_LAT;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},  BUSY, 0);
        check({tag, "_done"},  DONE, 0);
        check({tag, "_valid"}, BFLY_VALID, 0);
        check({tag, "_wr_en"}, WR_EN, 0);
        check({tag, "_addra"}, ADDRA, 0);
        check({tag, "_addrb"}, ADDRB, 0);
        check({tag, "_tw"},    TW_IDX, 0);
        check({tag, "_stage"}, STAGE, 0);
        check({tag, "_wr_a"},  WR_ADDRA, 0);
        check({tag, "_wr_b"},  WR_ADDRB, 0);
`ifdef FFT_AG_BITREV_EN
        check({tag, "_load_valid"}, LOAD_VALID, 0);
        check({tag, "_load_addr"},  LOAD_ADDR, 0);
`endif
    endtask

    task automatic check_output(input int k);
        check("bfly_valid", BFLY_VALID, ev[k]);
        if (ev[k]) begin
            check("addra",  ADDRA,  ea[k]);
            check("addrb",  ADDRB,  eb[k]);
            check("tw_idx", TW_IDX, etw[k]);
            check("stage",  STAGE,  est[k]);
        end
        check("wr_en", WR_EN, ew[k]);
        if (ew[k]) begin
            check("wr_addra", WR_ADDRA, ewa[k]);
            check("wr_addrb", WR_ADDRB, ewb[k]);
        end
        check("done", DONE, (k == done_off) ? 1 : 0);
        check("busy", BUSY, (k == done_off) ? 0 : 1);
`ifdef FFT_AG_BITREV_EN
        check("load_valid", LOAD_VALID, el[k]);
        if (el[k]) check("load_addr", LOAD_ADDR, eladdr[k]);
`endif
    endtask

    // One run: START at the next edge, then per-cycle checks until DONE or abort.
    task automatic apply_stimulus(input int pct, input int stall_from, input int stall_len,
                                  input bit hold_start, input bit do_abort);
        int abort_at;
        build_schedule(pct, stall_from, stall_len);
        abort_at = do_abort ? stage1_off + 2 : -1;
        START = 1'b1;
        STALL = 1'b0;
        @(negedge CLK);
        check("busy_accept",  BUSY, 1);
        check("valid_accept", BFLY_VALID, 0);
        if (!hold_start) START = 1'b0;
        for (int k = 1; k <= done_off; k++) begin
            STALL = stall_at[k];
            if (k == abort_at) RST = 1'b1;
            @(negedge CLK);
            if (k == abort_at) begin
                check_reset_state("abort");
                RST   = 1'b0;
                START = 1'b0;
                STALL = 1'b0;
                for (int q = 0; q < 2 * PIPE_LAT + 4; q++) begin
                    @(negedge CLK);
                    check("post_abort_wr_en", WR_EN, 0);
                    check("post_abort_done",  DONE, 0);
                    check("post_abort_valid", BFLY_VALID, 0);
                    check("post_abort_busy",  BUSY, 0);
                end
                return;
            end
            check_output(k);
        end
        STALL = 1'b0;
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        STALL = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_state("reset");
        RST = 1'b0;
        @(negedge CLK);
        check("idle_busy", BUSY, 0);

        $display("[TB] plain run, no stall");
        apply_stimulus(0, -1, 0, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);

        $display("[TB] three stall cycles mid stage 2");
        apply_stimulus(0, 24, 3, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);

        $display("[TB] random stalls with START held, then back-to-back run");
        apply_stimulus(25, -1, 0, 1'b1, 1'b0);
        apply_stimulus(0, -1, 0, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);

        $display("[TB] reset during stage 1, then fresh run");
        apply_stimulus(20, -1, 0, 1'b0, 1'b1);
        apply_stimulus(30, -1, 0, 1'b0, 1'b0);

        for (int q = 0; q < 4; q++) begin
            @(negedge CLK);
            check("tail_idle_busy",  BUSY, 0);
            check("tail_idle_wr_en", WR_EN, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
